pc_redirect_arbiter: RTL
========================

Name: pc_redirect_arbiter

Overview:
- Sequences the program-counter register: owns its `npc`, `npc_enn` and `n_stall` inputs.
- Arbitrates the PC redirect sources (trap, EX branch/jalr resolution, ID jal) by a fixed priority.
- Buffers a redirect that arrives during a pipeline stall and applies it when the stall releases.
- Emits IF/ID flush strobes, holds the PC frozen for a boot window after reset, and counts applied redirects.

Parameters:
- `ADDR_W`, 27: PC / target width.
- `RESET_PC`, 16268: value driven on `npc` at reset and during BOOT.
- `BOOT_CYCLES`, 4: cycles `n_stall` is held low after reset deasserts.
- `CNT_W`, 32: redirect counter width.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `stall_i`, in, 1: pipeline hazard/memory backpressure.
- `trap_valid`, in, 1: trap/irq redirect request.
- `trap_target`, in, `ADDR_W`: trap vector.
- `ex_valid`, in, 1: EX-stage redirect (taken branch, jalr).
- `ex_target`, in, `ADDR_W`: EX redirect target.
- `id_valid`, in, 1: ID-stage redirect (jal).
- `id_target`, in, `ADDR_W`: ID redirect target.
- `npc`, out, `ADDR_W`: next PC to the PC register.
- `npc_enn`, out, 1: load `npc` into the PC register.
- `n_stall`, out, 1: PC register update enable.
- `flush_if`, out, 1: kill the instruction in IF.
- `flush_id`, out, 1: kill the instruction in ID.
- `misalign`, out, 1: pulse when an applied target has bits [1:0] != 0.
- `redirect_count`, out, `CNT_W`: number of applied redirects.

Behaviour:
- Reset:
  - state=BOOT, boot counter=0, pending cleared.
  - `npc`=`RESET_PC`; `npc_enn`, `n_stall`, `flush_if`, `flush_id`, `misalign` = 0; `redirect_count`=0.
  - `rst` asserted in any state, including HOLD with a pending redirect, discards the pending redirect and returns to BOOT.
- Source rank: trap=3 > ex=2 > id=1.
  - The selected request is the highest-ranked valid input. A lower-ranked input in the same cycle is dropped, not queued: the younger instruction is killed by the flush.
- States:
  - BOOT:
    - `n_stall`=0 and `npc_enn`=0; all requests are ignored.
    - The counter increments each cycle. When the counter reaches `BOOT_CYCLES-1`, go to RUN.
    - `BOOT_CYCLES`=0 goes directly to RUN after reset.
  - RUN, no stall (`stall_i`=0):
    - `n_stall`=1.
    - If any request is valid: `npc_enn`=1 and `npc`=the selected target, combinationally in the same cycle (zero latency). The PC loads it at the next edge.
    - Otherwise `npc_enn`=0 and `npc` holds its last value (don't-care).
  - RUN, stall (`stall_i`=1):
    - `n_stall`=0.
    - A valid request is latched into the pending register (target and rank); go to HOLD. `npc_enn`=0.
  - HOLD, `stall_i`=1:
    - `n_stall`=0.
    - A new request with rank >= the pending rank overwrites the pending register (on equal rank, the newer request wins). A lower rank is ignored.
  - HOLD, `stall_i`=0:
    - `n_stall`=1, `npc_enn`=1, `npc`=merge(pending, current inputs) using the same rank rule; go to RUN.
    - The pending register clears at the edge.
- Flush, asserted in the cycle a redirect is applied (`npc_enn`=1 and `n_stall`=1):
  - `flush_if`=1 for every applied redirect.
  - `flush_id`=1 only when the applied source is trap or ex.
  - Flush is never asserted while `n_stall`=0.
- Alignment:
  - The applied `npc` has bits [1:0] forced to 0.
  - `misalign`=1 in that same cycle if the raw target's low bits were nonzero.
- Counter:
  - `redirect_count` increments by 1 at each edge where `npc_enn` && `n_stall`.
  - Wraps modulo 2^`CNT_W`.
- No request is ever lost across a stall, except a lower-ranked one superseded as above.

Decomposition:
- Shared package `cpu_pkg`:
  - `ADDR_W` and `RESET_PC` constants.
  - `redir_src_e` enum (NONE=0, ID=1, EX=2, TRAP=3).
  - `redir_t` struct (src, target).
  - `state_e` enum (BOOT, RUN, HOLD).
- One sub-module, `redir_prio_sel`: a combinational 3-input-plus-pending rank selector returning a `redir_t`. It is reused for both the live-select path and the HOLD merge path.

Test Plan:
- Reset, idle 6 cycles (`BOOT_CYCLES`=4) -> `n_stall`=0 for cycles 0-3 after reset release, then 1; `npc_enn`=0 throughout; `npc`=16268.
- RUN, no stall, `ex_valid`=1 with `ex_target`=0x100 and `id_valid`=1 with `id_target`=0x200 in the same cycle -> same cycle `npc`=0x100, `npc_enn`=1, `flush_if`=1, `flush_id`=1; `redirect_count`: 0->1.
- Stall for 3 cycles:
  - Cycle 1: `id_valid`, target 0x40. Cycle 2: `ex_valid`, target 0x80. Cycle 3: `id_valid`, target 0xC0.
  - `stall_i` drops in cycle 4.
  - -> `npc_enn`=0 in cycles 1-3; cycle 4: `npc`=0x80, `npc_enn`=1, `flush_id`=1.
- HOLD with pending ex 0x80; release cycle also carries `trap_valid` with target 0x10 -> `npc`=0x10, `flush_id`=1, pending cleared; `redirect_count` +1 only.
- `id_target`=0x103 applied without stall -> `npc`=0x100, `misalign`=1 for one cycle, `flush_id`=0.
- `rst` asserted while in HOLD with pending 0x80 -> after `rst` deasserts, BOOT again; no redirect is ever applied; `redirect_count`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the PC redirect path: source ranks,
// the redirect record and the sequencer states.
package cpu_pkg;

    localparam int ADDR_W = 27;
    localparam logic [ADDR_W-1:0] RESET_PC = 27'd16268;

    // Encoded value doubles as the priority rank used by the selector.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        ID   = 2'd1,
        EX   = 2'd2,
        TRAP = 2'd3
    } redir_src_e;

    typedef struct packed {
        redir_src_e        src;
        logic [ADDR_W-1:0] target;
    } redir_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] t);
        return {t[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_redirect_arbiter_if.sv
// Redirect request / PC-register control bundle between the pipeline and
// the redirect arbiter.
interface pc_redirect_arbiter_if #(
    parameter int CNT_W = 32
);
    logic                        stall_i;
    logic                        trap_valid;
    logic [cpu_pkg::ADDR_W-1:0]  trap_target;
    logic                        ex_valid;
    logic [cpu_pkg::ADDR_W-1:0]  ex_target;
    logic                        id_valid;
    logic [cpu_pkg::ADDR_W-1:0]  id_target;
    logic [cpu_pkg::ADDR_W-1:0]  npc;
    logic                        npc_enn;
    logic                        n_stall;
    logic                        flush_if;
    logic                        flush_id;
    logic                        misalign;
    logic [CNT_W-1:0]            redirect_count;

    modport master (
        output stall_i, trap_valid, trap_target, ex_valid, ex_target,
               id_valid, id_target,
        input  npc, npc_enn, n_stall, flush_if, flush_id, misalign,
               redirect_count
    );

    modport slave (
        input  stall_i, trap_valid, trap_target, ex_valid, ex_target,
               id_valid, id_target,
        output npc, npc_enn, n_stall, flush_if, flush_id, misalign,
               redirect_count
    );
endinterface

// File: rtl/redir_prio_sel.sv
// Fixed-rank redirect selector: picks the highest live request, then lets it
// replace the pending one when its rank is equal or higher.
module redir_prio_sel
    import cpu_pkg::*;
(
    input  logic              i_trap_valid,
    input  logic [ADDR_W-1:0] i_trap_target,
    input  logic              i_ex_valid,
    input  logic [ADDR_W-1:0] i_ex_target,
    input  logic              i_id_valid,
    input  logic [ADDR_W-1:0] i_id_target,
    input  redir_t            i_pend,
    output redir_t            o_sel
);
    redir_t w_live;

    always_comb begin
        w_live = '{src: NONE, target: '0};
        if (i_trap_valid) begin
            w_live = '{src: TRAP, target: i_trap_target};
        end else if (i_ex_valid) begin
            w_live = '{src: EX, target: i_ex_target};
        end else if (i_id_valid) begin
            w_live = '{src: ID, target: i_id_target};
        end

        // Ties go to the live request: it is the newer one.
        o_sel = i_pend;
        if (w_live.src != NONE && w_live.src >= i_pend.src) begin
            o_sel = w_live;
        end
    end
endmodule

// File: rtl/pc_redirect_arbiter.sv
// PC redirect sequencer: boot hold, zero-latency redirect, stall buffering
// with rank-based merge, flush strobes and applied-redirect counter.
//
//   state | meaning
//   BOOT  | PC frozen at RESET_PC for BOOT_CYCLES, requests ignored
//   RUN   | redirects applied immediately when not stalled
//   HOLD  | one redirect buffered across a stall, merged on release
module pc_redirect_arbiter
    import cpu_pkg::*;
#(
    parameter int BOOT_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pc_redirect_arbiter_if.slave  bus
);
    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BW-1:0] BOOT_LAST = (BOOT_CYCLES > 0) ? BW'(BOOT_CYCLES - 1) : '0;
    localparam state_e RESET_STATE = (BOOT_CYCLES == 0) ? RUN : BOOT;
    localparam redir_t PEND_NONE = '{src: NONE, target: '0};

    state_e            r_state;
    logic [BW-1:0]     r_boot_cnt;
    redir_t            r_pend;
    logic [ADDR_W-1:0] r_npc_last;
    logic [CNT_W-1:0]  r_cnt;

    state_e            w_state_nxt;
    logic [BW-1:0]     w_boot_cnt_nxt;
    redir_t            w_pend_nxt;
    redir_t            w_sel;
    logic [ADDR_W-1:0] w_npc;
    logic              w_npc_enn;
    logic              w_n_stall;
    logic              w_flush_if;
    logic              w_flush_id;
    logic              w_misalign;
    logic              w_apply;

    // Pending is always NONE outside HOLD, so one selector serves both the
    // live path and the release merge.
    redir_prio_sel u_sel (
        .i_trap_valid  (bus.trap_valid),
        .i_trap_target (bus.trap_target),
        .i_ex_valid    (bus.ex_valid),
        .i_ex_target   (bus.ex_target),
        .i_id_valid    (bus.id_valid),
        .i_id_target   (bus.id_target),
        .i_pend        (r_pend),
        .o_sel         (w_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RESET_STATE;
            r_boot_cnt <= '0;
            r_pend     <= PEND_NONE;
            r_npc_last <= RESET_PC;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_boot_cnt <= w_boot_cnt_nxt;
            r_pend     <= w_pend_nxt;
            if (w_apply) begin
                r_npc_last <= w_npc;
                r_cnt      <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_boot_cnt_nxt = r_boot_cnt;
        w_pend_nxt     = r_pend;
        w_npc          = r_npc_last;
        w_npc_enn      = 1'b0;
        w_n_stall      = 1'b0;
        w_flush_if     = 1'b0;
        w_flush_id     = 1'b0;
        w_misalign     = 1'b0;

        case (r_state)
            BOOT: begin
                w_npc          = RESET_PC;
                w_boot_cnt_nxt = r_boot_cnt + BW'(1);
                if (r_boot_cnt == BOOT_LAST) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!bus.stall_i) begin
                    w_n_stall = 1'b1;
                    if (w_sel.src != NONE) begin
                        w_npc_enn = 1'b1;
                        w_npc     = align_pc(w_sel.target);
                    end
                end else if (w_sel.src != NONE) begin
                    w_pend_nxt  = w_sel;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.stall_i) begin
                    w_pend_nxt = w_sel;
                end else begin
                    w_n_stall   = 1'b1;
                    w_npc_enn   = 1'b1;
                    w_npc       = align_pc(w_sel.target);
                    w_pend_nxt  = PEND_NONE;
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase

        if (w_npc_enn && w_n_stall) begin
            w_flush_if = 1'b1;
            w_flush_id = (w_sel.src == TRAP) || (w_sel.src == EX);
            w_misalign = |w_sel.target[1:0];
        end

        // Hold the PC-register controls quiet while reset is applied.
        if (rst) begin
            w_npc      = RESET_PC;
            w_npc_enn  = 1'b0;
            w_n_stall  = 1'b0;
            w_flush_if = 1'b0;
            w_flush_id = 1'b0;
            w_misalign = 1'b0;
        end
    end

    assign w_apply = w_npc_enn && w_n_stall;

    assign bus.npc            = w_npc;
    assign bus.npc_enn        = w_npc_enn;
    assign bus.n_stall        = w_n_stall;
    assign bus.flush_if       = w_flush_if;
    assign bus.flush_id       = w_flush_id;
    assign bus.misalign       = w_misalign;
    assign bus.redirect_count = r_cnt;
endmodule
